// File: rtl/i2c_slave_ctrl.sv
// Protocol sequencer for a read-only I2C slave: address receive, address ACK/NACK,
// byte load/transmit and master-ACK checking, steering the SDA output selector.
module i2c_slave_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       check_ack,
    input  logic       ack_done,
    input  logic       rw_mode,
    input  logic       address_match,
    input  logic       sda_in,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       read_enable,
    output logic       load_data,
    output logic [1:0] sda_mode
);

    typedef enum logic [3:0] {
        StIdle,
        StAddrRx,
        StAddrChk,
        StAckWait,
        StAckDrive,
        StNackWait,
        StNackDrive,
        StLoad,
        StTxByte,
        StMackWait,
        StMackDone
    } state_e;

    state_e state;

    // Bus events override everything; STOP wins when both arrive together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= StIdle;
        end else if (stop_found) begin
            state <= StIdle;
        end else if (start_found) begin
            state <= StAddrRx;
        end else begin
            case (state)
                StIdle:      state <= StIdle;
                StAddrRx:    if (byte_received) state <= StAddrChk;
                StAddrChk:   state <= (address_match && rw_mode) ? StAckWait : StNackWait;
                StAckWait:   if (ack_prep) state <= StAckDrive;
                StAckDrive:  if (ack_done) state <= StLoad;
                StNackWait:  if (ack_prep) state <= StNackDrive;
                StNackDrive: if (ack_done) state <= StIdle;
                StLoad:      state <= StTxByte;
                StTxByte:    if (ack_prep) state <= StMackWait;
                StMackWait:  if (check_ack) state <= sda_in ? StIdle : StMackDone;
                StMackDone:  if (ack_done) state <= StLoad;
                default:     state <= StIdle;
            endcase
        end
    end

    always_comb begin
        rx_enable   = 1'b0;
        tx_enable   = 1'b0;
        read_enable = 1'b0;
        load_data   = 1'b0;
        sda_mode    = 2'b00;
        case (state)
            StAddrRx:    rx_enable = 1'b1;
            StAckDrive:  sda_mode = 2'b01;
            StNackDrive: sda_mode = 2'b10;
            StLoad: begin
                load_data   = 1'b1;
                read_enable = 1'b1;
            end
            StTxByte: begin
                tx_enable = 1'b1;
                sda_mode  = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
